registrador_sipo_rx: RTL and testbench
======================================

# registrador_sipo_rx

Serial-in / parallel-out receiver: the receiving end of the 8-bit parallel-load shift-register link. It accepts the serial stream driven by the transmitter's Q7 output, framed by the same active-low load strobe, and reassembles it into a parallel word. It presents the word on a holding latch with a valid/ack handshake and flags words lost to overrun. It sits between the serial link and the parallel consumer logic.

## Interface

**Parameters**
- `WIDTH`, default 8: frame length in bits and parallel word width (≥ 2).

**Ports**
- `clock` in 1: single system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `PL_` in 1: active-low frame start, mirroring the transmitter's load strobe. Sampled synchronously.
- `CE_` in 1: active-low shift enable (clock-inhibit equivalent). A bit is sampled only on cycles where it is low.
- `DS` in 1: serial data, MSB first.
- `Q` out WIDTH: latched received word.
- `valid` out 1: `Q` holds an unacknowledged word.
- `ack` in 1: consumer accepts `Q`. Effective only while `valid`=1.
- `overrun` out 1: sticky. A completed word replaced an unacknowledged one.
- `busy` out 1: a frame is in progress (state SHIFT).

## Operation
- Reset values: `Q`=0, `valid`=0, `overrun`=0, `busy`=0. Internal state: IDLE, count=0, shift register=0.
- **FSM: IDLE**
  - `CE_` and `DS` are ignored.
  - `PL_`=0 → go to SHIFT, count←0, shift register←0.
- **FSM: SHIFT**
  - `PL_`=0: restart the frame (count←0, shift register←0). The partial word is discarded and `Q` is untouched. `PL_` has priority over `CE_`: a bit presented in the same cycle is dropped.
  - `PL_`=1, `CE_`=0, count<WIDTH−1: shift register←{sr[WIDTH−2:0], DS}, count←count+1.
  - `PL_`=1, `CE_`=0, count=WIDTH−1: `Q`←{sr[WIDTH−2:0], DS}, `valid`←1, go to IDLE.
  - `PL_`=1, `CE_`=1: hold all state; no timeout.
- Bit order: the first sampled bit lands in `Q[WIDTH−1]` and the last in `Q[0]`.
- Handshake:
  - `ack`=1 with `valid`=1 clears `valid` on the next edge.
  - `ack` with `valid`=0 is ignored.
- Completion while `valid`=1 and `ack`=0: `Q` is overwritten with the new word, `valid` stays 1, and `overrun`←1. `overrun` is cleared only by `reset`.
- Completion and `ack` in the same cycle: new `Q`, `valid` stays 1, no overrun.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH−1 and does not wrap silently.

## Timing
- Frame-start latency: `PL_` low at edge k → `busy`=1 after edge k.
- Bit sampling happens on the rising edge where `CE_`=0. `DS` must be stable around that edge.
- Last bit sampled at edge n → `Q`, `valid` and `overrun` update at edge n, and `busy`=0 after edge n.
- Minimum frame: 1 `PL_` cycle followed by WIDTH enabled cycles, i.e. WIDTH+1 clocks.
- Back-to-back frames: `PL_` may be asserted in the cycle right after completion.
- Asynchronous `reset` mid-frame: the partial word is lost, outputs go to their reset values immediately, and the FSM returns to IDLE.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `registrador_pkg` holds:
  - the state enum `rx_state_t` {IDLE, SHIFT};
  - `RDP_WIDTH`=8, the link word width shared with the transmitter.
- One sub-module, `sipo_shift_core`, contains the shift register and bit counter. Its ports are clear, shift_en, DS, count, and word.
- The top level contains the FSM, the `Q` latch, and the valid/overrun logic.

## Test plan
- **Reset:** assert `reset` mid-frame after 3 bits → `Q`=0, `valid`=0, `busy`=0 immediately. A subsequent full frame is received correctly.
- **Basic frame:** `PL_` low for 1 cycle, then `DS`=0,0,1,0,1,0,1,0 with `CE_`=0 → `Q`=8'h2A and `valid`=1 at the 8th bit edge. `ack` → `valid`=0.
- **Clock inhibit:** same frame with `CE_`=1 for 3 cycles inserted after bit 4 (`DS` toggling during the gap) → `Q`=8'h2A and `busy`=1 throughout the gap.
- **Restart:** send 5 bits, then pulse `PL_`, then send 8'hD5 → `Q`=8'hD5 and `valid` pulses once. Repeat with `PL_`=0 and `CE_`=0 in the same cycle → that bit is discarded.
- **Overrun:** receive 8'h2A without `ack`, then 8'hFF → `Q`=8'hFF, `valid`=1, `overrun`=1. `ack` → `valid`=0 and `overrun` stays 1.
- **Concurrent ack:** `ack` on the same edge that completes 8'h81 while `valid`=1 → `Q`=8'h81, `valid`=1, `overrun`=0.

Source files
------------

// File: rtl/registrador_pkg.sv
// Shared definitions for the 8-bit parallel-load shift-register link.
// Used by both the serial receiver and its shift core.
package registrador_pkg;

    localparam int RDP_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus saturating bit counter for the serial receiver.
// clear has priority over shift_en; the counter stops at WIDTH-1 and never wraps.
module sipo_shift_core
    import registrador_pkg::*;
#(
    parameter  int WIDTH = RDP_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             DS,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] word
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sr_q, sr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        sr_d    = sr_q;
        if (clear) begin
            count_d = '0;
            sr_d    = '0;
        end else if (shift_en) begin
            sr_d = {sr_q[WIDTH-2:0], DS};
            if (count_q != LAST) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sr_q    <= '0;
        end else begin
            count_q <= count_d;
            sr_q    <= sr_d;
        end
    end

    assign count = count_q;
    assign word  = sr_q;

endmodule

// File: rtl/registrador_sipo_rx.sv
// Serial-in / parallel-out receiver: frames on PL_, samples DS while CE_ is low,
// and presents the word on a holding register with a valid/ack handshake and sticky overrun.
module registrador_sipo_rx
    import registrador_pkg::*;
#(
    parameter  int WIDTH = RDP_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             PL_,
    input  logic             CE_,
    input  logic             DS,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    input  logic             ack,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    rx_state_t        state_q;
    logic [WIDTH-1:0] q_q;
    logic             valid_q;
    logic             overrun_q;

    logic             clear;
    logic             shift_en;
    logic             complete;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] word;
    logic             unused_msb;

    assign clear      = !PL_;
    assign shift_en   = (state_q == SHIFT) && PL_ && !CE_;
    assign complete   = shift_en && (count == LAST);
    assign unused_msb = word[WIDTH-1];

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .shift_en (shift_en),
        .DS       (DS),
        .count    (count),
        .word     (word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    if (!PL_)     state_q <= SHIFT;
                SHIFT:   if (complete) state_q <= IDLE;
                default:               state_q <= IDLE;
            endcase

            // A completing word wins over ack; ack only rescues it from counting as overrun.
            if (complete) begin
                q_q     <= {word[WIDTH-2:0], DS};
                valid_q <= 1'b1;
                if (valid_q && !ack) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Q       = q_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_registrador_sipo_rx.sv
// Scoreboard bench for registrador_sipo_rx: stimulus pushes expected words,
// a negedge monitor pops and compares on every frame completion.
module tb_registrador_sipo_rx;

    typedef struct {
        logic [7:0] q;
        logic       valid;
        logic       overrun;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       PL_;
    logic       CE_;
    logic       DS;
    logic [7:0] Q;
    logic       valid;
    logic       ack;
    logic       overrun;
    logic       busy;

    exp_t sb[$];
    int   checks      = 0;
    int   failures    = 0;
    int   completions = 0;
    int   pushes      = 0;
    logic prev_busy   = 1'b0;

    registrador_sipo_rx #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .PL_     (PL_),
        .CE_     (CE_),
        .DS      (DS),
        .Q       (Q),
        .valid   (valid),
        .ack     (ack),
        .overrun (overrun),
        .busy    (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Completion = busy falling while valid is set (reset clears valid, so it never matches).
    always @(negedge clock) begin
        if (prev_busy && !busy && valid) begin
            completions++;
            if (sb.size() == 0) begin
                check("unexpected_word", {24'h0, Q}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_q",       {24'h0, Q},   {24'h0, e.q});
                check("sb_valid",   {31'h0, valid},   {31'h0, e.valid});
                check("sb_overrun", {31'h0, overrun}, {31'h0, e.overrun});
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        PL_ = 1'b0;
        CE_ = 1'b1;
        tick();
        PL_ = 1'b1;
    endtask

    task automatic shift_bits(input logic [7:0] w, input int first, input int last, input logic ack_last);
        for (int i = first; i >= last; i--) begin
            DS  = w[i];
            CE_ = 1'b0;
            if (i == 0) ack = ack_last;
            tick();
        end
        CE_ = 1'b1;
        ack = 1'b0;
    endtask

    task automatic expect_word(input logic [7:0] w, input logic ov);
        sb.push_back('{q: w, valid: 1'b1, overrun: ov});
        pushes++;
    endtask

    task automatic send_word(input logic [7:0] w, input logic ov, input logic ack_last);
        start_frame();
        expect_word(w, ov);
        shift_bits(w, 7, 0, ack_last);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int c0;
        reset = 1'b1;
        PL_   = 1'b1;
        CE_   = 1'b1;
        DS    = 1'b0;
        ack   = 1'b0;
        #12;
        check("rst_q",       {24'h0, Q}, 32'h0);
        check("rst_valid",   {31'h0, valid}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_busy",    {31'h0, busy}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Basic frame
        send_word(8'h2A, 1'b0, 1'b0);
        check("basic_valid", {31'h0, valid}, 32'h1);
        do_ack();
        check("basic_ack_valid", {31'h0, valid}, 32'h0);

        // Reset mid-frame after 3 bits
        start_frame();
        shift_bits(8'hE0, 7, 5, 1'b0);
        check("midrst_busy_before", {31'h0, busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_q",     {24'h0, Q}, 32'h0);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_busy",  {31'h0, busy}, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0);
        do_ack();

        // Clock inhibit gap after bit 4, DS toggling
        start_frame();
        expect_word(8'h2A, 1'b0);
        shift_bits(8'h2A, 7, 4, 1'b0);
        for (int g = 0; g < 3; g++) begin
            DS  = g[0];
            CE_ = 1'b1;
            tick();
            check("gap_busy", {31'h0, busy}, 32'h1);
        end
        shift_bits(8'h2A, 3, 0, 1'b0);
        do_ack();

        // Restart after 5 bits
        c0 = completions;
        start_frame();
        shift_bits(8'hFF, 7, 3, 1'b0);
        send_word(8'hD5, 1'b0, 1'b0);
        tick();
        check("restart_pulses", completions, c0 + 1);
        do_ack();

        // Restart with PL_ and CE_ low together: that bit must be dropped
        start_frame();
        shift_bits(8'hFF, 7, 3, 1'b0);
        PL_ = 1'b0;
        CE_ = 1'b0;
        DS  = 1'b1;
        tick();
        PL_ = 1'b1;
        expect_word(8'hD5, 1'b0);
        shift_bits(8'hD5, 7, 0, 1'b0);
        do_ack();

        // Concurrent ack on the completing edge: no overrun
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'h81, 1'b0, 1'b1);
        check("conc_overrun", {31'h0, overrun}, 32'h0);
        do_ack();
        check("conc_ack_valid", {31'h0, valid}, 32'h0);

        // Overrun
        send_word(8'h2A, 1'b0, 1'b0);
        send_word(8'hFF, 1'b1, 1'b0);
        do_ack();
        check("ovr_ack_valid",   {31'h0, valid}, 32'h0);
        check("ovr_ack_overrun", {31'h0, overrun}, 32'h1);

        tick();
        tick();
        check("sb_empty", sb.size(), 32'h0);
        check("completions", completions, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
